// File: rtl/apb_pkg.sv
// Shared types for the APB initiator: FSM state encoding and the captured command payload.
package apb_pkg;

    localparam int unsigned APB_BW     = 64;
    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_SW     = APB_BW / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_BW-1:0]     wdata;
        logic [APB_SW-1:0]     strb;
    } apb_cmd_t;

    // Reads never drive byte strobes.
    function automatic logic [APB_SW-1:0] eff_strb(input logic write, input logic [APB_SW-1:0] strb);
        return write ? strb : '0;
    endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Counts consecutive stalled ACCESS cycles; expire_c flags the cycle that reaches LIMIT.
module apb_timeout_cnt #(
    parameter int unsigned LIMIT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count,
    output logic expire_c
);

    localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] cnt_q;

    assign expire_c = count && (cnt_q == CW'(LIMIT - 1));

    // Stall counter: cleared before each transfer, saturates at expiry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (count && !expire_c) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/apb_master.sv
// APB initiator: valid/ready command in, SETUP/ACCESS transfer out, valid/ready response back.
// One transfer outstanding at a time; all outputs come straight from flops.
// Optional build macro APB_TIMEOUT_EN aborts an ACCESS phase stalled for TIMEOUT_CYCLES cycles.
// BW and ADDR_W must match the payload widths declared in apb_pkg.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned BW             = APB_BW,
    parameter int unsigned ADDR_W         = APB_ADDR_W,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [BW-1:0]     cmd_wdata_i,
    input  logic [BW/8-1:0]   cmd_strb_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [BW-1:0]     rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              psel_o,
    output logic              penable_o,
    output logic              pwrite_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic [BW-1:0]     pwdata_o,
    output logic [BW/8-1:0]   pstrb_o,
    input  logic [BW-1:0]     prdata_i,
    input  logic              pready_i,
    input  logic              pslverr_i
);

    localparam int unsigned SW = BW / 8;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_master: TIMEOUT_CYCLES must be at least 1");
    end

    apb_state_e    state_q, state_d;
    apb_cmd_t      cmd_q, cmd_d;
    logic          psel_q, psel_d;
    logic          penable_q, penable_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [BW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          abort_c;

`ifdef APB_TIMEOUT_EN
    apb_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk_i),
        .rst      (reset_i),
        .clear    (state_q == SETUP),
        .count    ((state_q == ACCESS) && !pready_i),
        .expire_c (abort_c)
    );
`else
    assign abort_c = 1'b0;
`endif

    // Next-state and next-output logic; every register holds unless a transition updates it.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        cmd_ready_d = cmd_ready_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    cmd_d.write = cmd_write_i;
                    cmd_d.addr  = APB_ADDR_W'(cmd_addr_i);
                    cmd_d.wdata = APB_BW'(cmd_wdata_i);
                    cmd_d.strb  = eff_strb(cmd_write_i, APB_SW'(cmd_strb_i));
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    cmd_ready_d = 1'b0;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (pready_i) begin
                    rsp_rdata_d = cmd_q.write ? '0 : prdata_i;
                    rsp_err_d   = pslverr_i;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (abort_c) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign psel_o      = psel_q;
    assign penable_o   = penable_q;
    assign pwrite_o    = cmd_q.write;
    assign paddr_o     = ADDR_W'(cmd_q.addr);
    assign pwdata_o    = BW'(cmd_q.wdata);
    assign pstrb_o     = SW'(cmd_q.strb);

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: transaction-timeline model checked every cycle plus literal spot checks.
module tb_apb_master;

    localparam int unsigned BW = 64;
    localparam int unsigned AW = 32;
    localparam int unsigned SW = BW / 8;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [BW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_strb;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [BW-1:0] rsp_rdata;
    logic          psel, penable, pwrite, pready, pslverr;
    logic [AW-1:0] paddr;
    logic [BW-1:0] pwdata, prdata;
    logic [SW-1:0] pstrb;

    always #5 clk = ~clk;

    apb_master #(.BW(BW), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_strb_i(cmd_strb),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .paddr_o(paddr),
        .pwdata_o(pwdata), .pstrb_o(pstrb), .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Current transaction as the model sees it: accept cycle, wait states, response hold.
    logic          m_active = 1'b0;
    logic          chk_en   = 1'b0;
    int            m_t0, m_acc, m_hold;
    logic          m_write, m_err;
    logic [AW-1:0] m_addr;
    logic [BW-1:0] m_wdata, m_rdata;
    logic [SW-1:0] m_strb;

    // Per-offset samples of the latest transaction, for literal spot checks.
    logic          lg_psel [0:31];
    logic          lg_pen  [0:31];
    logic          lg_rv   [0:31];
    logic          lg_cr   [0:31];
    logic          lg_err  [0:31];
    logic [AW-1:0] lg_addr [0:31];
    logic [BW-1:0] lg_rdat [0:31];
    logic [BW-1:0] lg_wdat [0:31];
    logic [SW-1:0] lg_strb [0:31];

    // Model compare: offset k from accept gives 0 idle, 1 setup, 2..2+acc access, then response.
    always @(negedge clk) begin
        int k;
        if (!reset_i && chk_en) begin
            k = cyc - m_t0;
            if (!m_active || k < 1 || k > 3 + m_acc + m_hold) begin
                check("idle_cmd_ready", cmd_ready, 1);
                check("idle_psel", psel, 0);
                check("idle_penable", penable, 0);
                check("idle_rsp_valid", rsp_valid, 0);
            end else if (k <= 2 + m_acc) begin
                check("apb_cmd_ready", cmd_ready, 0);
                check("apb_psel", psel, 1);
                check("apb_penable", penable, (k >= 2) ? 1 : 0);
                check("apb_rsp_valid", rsp_valid, 0);
                check("apb_paddr", paddr, m_addr);
                check("apb_pwrite", pwrite, m_write);
                check("apb_pwdata", pwdata, m_wdata);
                check("apb_pstrb", pstrb, m_write ? m_strb : 0);
            end else begin
                check("rsp_cmd_ready", cmd_ready, 0);
                check("rsp_psel", psel, 0);
                check("rsp_penable", penable, 0);
                check("rsp_valid", rsp_valid, 1);
                check("rsp_rdata", rsp_rdata, m_write ? 0 : m_rdata);
                check("rsp_err", rsp_err, m_err);
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            cmd_valid = 0; pready = 0; pslverr = 0; rsp_ready = 0;
            cmd_addr  = $urandom;
        end
    endtask

    // One complete transfer: slave inserts `waits` stall cycles (or never answers if `to`),
    // and the consumer holds off rsp_ready for `hold` cycles.
    task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [BW-1:0] wd,
                        input logic [SW-1:0] st, input logic [BW-1:0] rd, input logic e,
                        input int waits, input int hold, input logic to);
        int acc, last;
        acc  = to ? TO - 1 : waits;
        last = 3 + acc + hold;
        for (int i = 0; i < 32; i++) begin
            lg_psel[i] = 0; lg_pen[i] = 0; lg_rv[i] = 0; lg_cr[i] = 0; lg_err[i] = 0;
            lg_addr[i] = 0; lg_rdat[i] = 0; lg_wdat[i] = 0; lg_strb[i] = 0;
        end
        for (int k = 0; k <= last; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                m_active = 1; m_t0 = cyc; m_write = w; m_addr = a; m_wdata = wd; m_strb = st;
                m_acc = acc; m_hold = hold;
                m_rdata = (to || w) ? '0 : rd;
                m_err = to ? 1'b1 : e;
            end
            cmd_valid = (k == 0);
            cmd_write = (k == 0) ? w : ~w;
            cmd_addr  = (k == 0) ? a : $urandom;
            cmd_wdata = (k == 0) ? wd : {$urandom, $urandom};
            cmd_strb  = (k == 0) ? st : 8'($urandom);
            pready    = !to && (k == 2 + waits);
            prdata    = pready ? rd : {$urandom, $urandom};
            pslverr   = pready ? e : 1'b1;
            rsp_ready = (k == last);
            @(negedge clk);
            if (k < 32) begin
                lg_psel[k] = psel; lg_pen[k] = penable; lg_rv[k] = rsp_valid; lg_cr[k] = cmd_ready;
                lg_err[k] = rsp_err; lg_addr[k] = paddr; lg_rdat[k] = rsp_rdata;
                lg_wdat[k] = pwdata; lg_strb[k] = pstrb;
            end
        end
    endtask

    initial begin
        int c;
        reset_i = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_strb = 0;
        rsp_ready = 0; prdata = 0; pready = 0; pslverr = 0;
        #12;
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_psel", psel, 0);
        check("reset_penable", penable, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_err", rsp_err, 0);
        check("reset_rsp_rdata", rsp_rdata, 0);
        check("reset_paddr", paddr, 0);
        @(posedge clk); #1;
        reset_i = 0; chk_en = 1;
        idle(2);

        // Zero-wait write: SETUP at N+1, ACCESS at N+2, response at N+3.
        xfer(1, 32'h0000_0010, 64'h1122334455667788, 8'hFF, 64'h0, 0, 0, 0, 0);
        check("w0_cr_n", lg_cr[0], 1);
        check("w0_psel_n1", lg_psel[1], 1);
        check("w0_pen_n1", lg_pen[1], 0);
        check("w0_pwdata_n1", lg_wdat[1], 64'h1122334455667788);
        check("w0_pen_n2", lg_pen[2], 1);
        check("w0_rv_n2", lg_rv[2], 0);
        check("w0_rv_n3", lg_rv[3], 1);
        check("w0_err_n3", lg_err[3], 0);

        // Read with three stall cycles: four ACCESS cycles, address stable.
        xfer(0, 32'h0000_0020, 64'h0, 8'hFF, 64'hDEADBEEF_CAFEF00D, 0, 3, 0, 0);
        c = 0;
        for (int k = 0; k < 32; k++) c += int'(lg_pen[k]);
        check("r3_access_cycles", c, 4);
        for (int k = 1; k <= 5; k++) check("r3_paddr_stable", lg_addr[k], 32'h0000_0020);
        check("r3_pstrb_read", lg_strb[1], 8'h00);
        check("r3_rv_n5", lg_rv[5], 0);
        check("r3_rv_n6", lg_rv[6], 1);
        check("r3_rdata", lg_rdat[6], 64'hDEADBEEF_CAFEF00D);

        // Slave error on a write with one stall cycle.
        xfer(1, 32'h0000_0030, 64'hA5A5_5A5A_0F0F_F0F0, 8'h0F, 64'h0, 1, 1, 0, 0);
        check("we_err", lg_err[4], 1);
        check("we_rdata", lg_rdat[4], 64'h0);

        // Response held off five cycles, then a back-to-back command.
        xfer(0, 32'h0000_0044, 64'h0, 8'hF0, 64'h0123_4567_89AB_CDEF, 0, 0, 5, 0);
        for (int k = 3; k <= 8; k++) begin
            check("hold_cmd_ready", lg_cr[k], 0);
            check("hold_rv", lg_rv[k], 1);
            check("hold_rdata", lg_rdat[k], 64'h0123_4567_89AB_CDEF);
        end
        xfer(1, 32'h0000_0048, 64'hFEED_FACE_0000_0001, 8'h3C, 64'h0, 0, 0, 0, 0);
        check("b2b_psel_n1", lg_psel[1], 1);
        check("b2b_strb_n1", lg_strb[1], 8'h3C);

        // Assorted transfers.
        xfer(0, 32'hFFFF_FFF8, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1, 2, 1, 0);
        xfer(1, 32'h8000_0000, 64'h0000_0000_0000_0000, 8'h01, 64'h0, 0, 5, 2, 0);
        xfer(0, 32'h0000_1000, 64'h0, 8'hAA, 64'h0000_0000_0000_0000, 0, 1, 3, 0);
        idle(2);

        // Asynchronous reset in the middle of ACCESS.
        @(posedge clk); #1;
        m_active = 1; m_t0 = cyc; m_write = 1; m_addr = 32'h60; m_wdata = 64'h77; m_strb = 8'hFF;
        m_acc = 100; m_hold = 0; m_rdata = 0; m_err = 0;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h60; cmd_wdata = 64'h77; cmd_strb = 8'hFF;
        pready = 0; pslverr = 0; rsp_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            cmd_valid = 0;
        end
        #2;
        reset_i = 1; m_active = 0;
        #1;
        check("arst_psel", psel, 0);
        check("arst_penable", penable, 0);
        check("arst_rsp_valid", rsp_valid, 0);
        @(negedge clk); #1;
        reset_i = 0;
        #1;
        check("arst_cmd_ready", cmd_ready, 1);
        idle(2);
        xfer(0, 32'h0000_0050, 64'h0, 8'hFF, 64'h1357_9BDF_2468_ACE0, 0, 0, 0, 0);
        check("post_rst_rdata", lg_rdat[3], 64'h1357_9BDF_2468_ACE0);

`ifdef APB_TIMEOUT_EN
        // Slave never answers: abort after TO stalled ACCESS cycles.
        xfer(0, 32'h0000_0080, 64'h0, 8'hFF, 64'h5555_5555_5555_5555, 0, 0, 0, 1);
        c = 0;
        for (int k = 0; k < 32; k++) c += int'(lg_pen[k]);
        check("to_access_cycles", c, 8);
        check("to_rv", lg_rv[10], 1);
        check("to_err", lg_err[10], 1);
        check("to_rdata", lg_rdat[10], 64'h0);
`endif

        idle(3);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
